// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and register-match helper for hazard_ctrl
//
// Purpose : state encoding, register-index width and the source-register
//           match function used by the hazard controller.
// Exports : hz_state_e, REG_W, REG_ZERO, reg_match()
package hazard_pkg;

   localparam int REG_W = 5;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MUL_BUSY = 1'b1
   } hz_state_e;

   // r matches the ID instruction's sources; x0 is hard-wired and never matches.
   function automatic logic reg_match(input logic [REG_W-1:0] r,
                                      input logic [REG_W-1:0] rs1,
                                      input logic [REG_W-1:0] rs2,
                                      input logic             uses_rs2);
      return (r != REG_ZERO) && ((r == rs1) || (uses_rs2 && (r == rs2)));
   endfunction

endpackage

// File: rtl/mul_occupancy_timer.sv
// rtl/mul_occupancy_timer.sv - down-counter tracking remaining EX occupancy of a multiply
//
// Purpose : loaded when a multiply enters MUL_BUSY, counts down while busy,
//           cleared by reset or redirect, flags when it has reached zero.
// Ports   : clk_i   clock
//           rst_i   synchronous active-low reset
//           load_i  RUN-to-MUL_BUSY transition this cycle
//           dec_i   in MUL_BUSY this cycle
//           clear_i redirect kills the multiply
//           zero_o  counter is zero
module mul_occupancy_timer #(
   parameter int MUL_CYCLES = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic dec_i,
   input  logic clear_i,
   output logic zero_o
);

   localparam int W = $clog2(MUL_CYCLES);
   localparam logic [W-1:0] LOAD_VAL = W'(MUL_CYCLES - 2);
   localparam logic [W-1:0] ONE      = W'(1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i || clear_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= LOAD_VAL;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - ONE;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use/branch stalls, multiply hold, redirect flush
//
// Purpose : drives the ID/EX bubble-mux selects and front-end enables, and
//           counts bubble cycles (saturating).
// Ports   : clk_i, rst_i (sync, active-low)
//           id_rs1_i, id_rs2_i, id_uses_rs2_i, id_branch_i, branch_taken_i  ID stage
//           ex_rd_i, ex_reg_write_i, ex_mem_read_i, ex_mul_i                 EX stage
//           mem_rd_i, mem_mem_read_i                                         MEM stage
//           redirect_i                                                       trap/redirect from MEM
//           pc_write_o, ifid_write_o, ifid_flush_o                           front-end controls
//           stall_select_o, flush_select_o, ex_hold_o, ex_flush_o            ID/EX and EX controls
//           bubble_cnt_o                                                     bubble-cycle counter
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MUL_CYCLES = 3,
   parameter int CNT_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs2_i,
   input  logic             id_branch_i,
   input  logic             branch_taken_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_reg_write_i,
   input  logic             ex_mem_read_i,
   input  logic             ex_mul_i,
   input  logic [4:0]       mem_rd_i,
   input  logic             mem_mem_read_i,
   input  logic             redirect_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             stall_select_o,
   output logic             flush_select_o,
   output logic             ex_hold_o,
   output logic             ex_flush_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   hz_state_e        state_q;
   logic             cnt_zero;
   logic             ex_match;
   logic             mem_match;
   logic             hold;
   logic             stall;
   logic             enter_mul;
   logic [CNT_W-1:0] bubble_cnt_q;

   assign ex_match  = reg_match(ex_rd_i, id_rs1_i, id_rs2_i, id_uses_rs2_i);
   assign mem_match = reg_match(mem_rd_i, id_rs1_i, id_rs2_i, id_uses_rs2_i);

   // The multiply holds from the cycle it is seen in EX until the timer drains;
   // the cycle where the timer reads zero is the release cycle.
   assign hold = ((state_q == ST_RUN) && ex_mul_i) ||
                 ((state_q == ST_MUL_BUSY) && !cnt_zero);

   // Branches compare in ID, so they need ALU results from EX and load data
   // from MEM that the forwarding network cannot yet provide.
   assign stall = (ex_mem_read_i && ex_match) ||
                  (id_branch_i && ((ex_reg_write_i && ex_match) ||
                                   (mem_mem_read_i && mem_match)));

   assign enter_mul = !redirect_i && (state_q == ST_RUN) && ex_mul_i;

   mul_occupancy_timer #(
      .MUL_CYCLES (MUL_CYCLES)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (enter_mul),
      .dec_i   (state_q == ST_MUL_BUSY),
      .clear_i (redirect_i),
      .zero_o  (cnt_zero)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_RUN;
      end else if (redirect_i) begin
         state_q <= ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:      if (ex_mul_i) state_q <= ST_MUL_BUSY;
            ST_MUL_BUSY: if (cnt_zero) state_q <= ST_RUN;
            default:     state_q <= ST_RUN;
         endcase
      end
   end

   // Mealy outputs. Taken-branch flush sits below HOLD and STALL because the
   // branch outcome is computed from stale operands in those cycles.
   always_comb begin
      pc_write_o     = 1'b1;
      ifid_write_o   = 1'b1;
      ifid_flush_o   = 1'b0;
      stall_select_o = 1'b0;
      flush_select_o = 1'b0;
      ex_hold_o      = 1'b0;
      ex_flush_o     = 1'b0;
      if (!rst_i) begin
         pc_write_o     = 1'b0;
         ifid_write_o   = 1'b0;
         ifid_flush_o   = 1'b1;
         flush_select_o = 1'b1;
         ex_flush_o     = 1'b1;
      end else if (redirect_i) begin
         ifid_flush_o   = 1'b1;
         flush_select_o = 1'b1;
         ex_flush_o     = 1'b1;
      end else if (hold) begin
         ex_hold_o    = 1'b1;
         ex_flush_o   = 1'b1;
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
      end else if (stall) begin
         stall_select_o = 1'b1;
         pc_write_o     = 1'b0;
         ifid_write_o   = 1'b0;
      end else if (id_branch_i && branch_taken_i) begin
         ifid_flush_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         bubble_cnt_q <= '0;
      end else if ((stall_select_o || ex_hold_o) && (bubble_cnt_q != '1)) begin
         bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;

endmodule
